// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the instruction-fetch front end.
package riscv_pkg;

    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [2:0] {
        REQ,
        WAIT,
        HOLD,
        DROP,
        FAULT
    } fetch_state_t;

    // A target is usable only if it lands on an instruction boundary.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Signal bundle between the fetch unit, instruction memory, decode and the
// branch-resolution path. The fetch unit sits on the master side.
interface pc_fetch_if #(
    parameter int WORD_SIZE = 32
) ();

    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [WORD_SIZE-1:0] imem_addr;
    logic                 imem_resp_valid;
    logic [WORD_SIZE-1:0] imem_resp_data;
    logic                 inst_valid;
    logic                 inst_ready;
    logic [WORD_SIZE-1:0] inst_data;
    logic [WORD_SIZE-1:0] inst_pc;
    logic                 redirect_valid;
    logic [WORD_SIZE-1:0] redirect_target;
    logic                 fetch_fault;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, fetch_fault,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect_valid, redirect_target
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc, fetch_fault,
        output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
               redirect_valid, redirect_target
    );

endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, keeps at most one memory request
// in flight, buffers one returned word for decode, and honours redirects from
// execute by squashing anything younger than the branch.
module pc_fetch
    import riscv_pkg::*;
#(
    parameter int                   WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = WORD_SIZE'(DEFAULT_RESET_VECTOR)
) (
    input logic        clk,
    input logic        rst,
    pc_fetch_if.master bus
);

    fetch_state_t         state;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] buf_data;
    logic [WORD_SIZE-1:0] buf_pc;
    logic                 fault_q;

    // A redirect in the same cycle suppresses both handshakes so nothing from
    // the wrong path is requested or handed to decode.
    assign bus.imem_req_valid = (state == REQ)  && !bus.redirect_valid && !rst;
    assign bus.inst_valid     = (state == HOLD) && !bus.redirect_valid && !rst;
    assign bus.imem_addr      = pc;
    assign bus.inst_data      = buf_data;
    assign bus.inst_pc        = buf_pc;
    assign bus.fetch_fault    = fault_q;

    // Fetch sequencing; redirects outrank every other event and FAULT is left only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= REQ;
            pc       <= RESET_VECTOR;
            buf_data <= '0;
            buf_pc   <= '0;
            fault_q  <= 1'b0;
        end else if (state != FAULT) begin
            if (bus.redirect_valid) begin
                if (is_misaligned(bus.redirect_target[1:0])) begin
                    state   <= FAULT;
                    fault_q <= 1'b1;
                end else begin
                    pc <= bus.redirect_target;
                    case (state)
                        WAIT, DROP: state <= bus.imem_resp_valid ? REQ : DROP;
                        default:    state <= REQ;
                    endcase
                end
            end else begin
                case (state)
                    REQ: begin
                        if (bus.imem_req_ready) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.imem_resp_valid) begin
                            buf_data <= bus.imem_resp_data;
                            buf_pc   <= pc;
                            pc       <= pc + WORD_SIZE'(INSTR_BYTES);
                            state    <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (bus.inst_ready) begin
                            state <= REQ;
                        end
                    end
                    DROP: begin
                        if (bus.imem_resp_valid) begin
                            state <= REQ;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule
